// File: rtl/mem_arbiter_if.sv
// Request/response types and the bus-port interface shared by the arbiter and its neighbours.
// A requester drives req and receives rsp through the slave modport of the arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] m_mode = 2'b11;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_spec;
    logic        mem_fence;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;

endpackage

interface mem_port_if;
  import mem_arbiter_pkg::*;

  mem_in_type  req;
  mem_out_type rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one shared bus port for instruction fetch (imem) and data (dmem) requests.
// Define MEM_ARB_FAIRNESS_EN to stop a stream of data grants from starving a waiting fetch.
//
// state  | meaning
// idle   | no transaction on the bus; choose among pending requests
// busy_i | instruction request owns the bus, waiting for bus ready
// busy_d | data request owns the bus, waiting for bus ready
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  mem_port_if.slave  imem,
  mem_port_if.slave  dmem,
  mem_port_if.master bus
);

`ifdef MEM_ARB_FAIRNESS_EN
  parameter int starve_limit = 4;
  localparam int cnt_w = $clog2(starve_limit + 1);

  logic [cnt_w-1:0] starve_cnt_q, starve_cnt_d;
`endif

  typedef enum logic [1:0] {
    idle   = 2'd0,
    busy_i = 2'd1,
    busy_d = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       pend_i_q, pend_i_d;
  logic       pend_d_q, pend_d_d;
  mem_in_type slot_i_q, slot_i_d;
  mem_in_type slot_d_q, slot_d_d;
  mem_in_type grant_q, grant_d;
  logic       issue_q, issue_d;

  logic cap_i, cap_d;
  logic want_i, want_d;
  logic instr_first;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= idle;
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
      slot_i_q <= '0;
      slot_d_q <= '0;
      grant_q  <= '0;
      issue_q  <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      slot_i_q <= slot_i_d;
      slot_d_q <= slot_d_d;
      grant_q  <= grant_d;
      issue_q  <= issue_d;
`ifdef MEM_ARB_FAIRNESS_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_i_d    = pend_i_q;
    pend_d_d    = pend_d_q;
    slot_i_d    = slot_i_q;
    slot_d_d    = slot_d_q;
    grant_d     = grant_q;
    issue_d     = 1'b0;
    instr_first = 1'b0;

    // A level-held valid is only a new request when nothing from that port is queued or on the bus.
    cap_i = imem.req.mem_valid && !imem.req.mem_spec && !pend_i_q && (state_q != busy_i);
    cap_d = dmem.req.mem_valid && !pend_d_q && (state_q != busy_d);

    if (cap_i) begin
      pend_i_d = 1'b1;
      slot_i_d = imem.req;
    end
    if (imem.req.mem_spec) begin
      pend_i_d = 1'b0;
    end
    if (cap_d) begin
      pend_d_d = 1'b1;
      slot_d_d = dmem.req;
    end

    want_i = pend_i_d;
    want_d = pend_d_d;

`ifdef MEM_ARB_FAIRNESS_EN
    instr_first = want_i && (starve_cnt_q == cnt_w'(starve_limit));
`endif

    case (state_q)
      idle: begin
        if (want_i && (!want_d || instr_first)) begin
          state_d  = busy_i;
          grant_d  = slot_i_d;
          pend_i_d = 1'b0;
          issue_d  = 1'b1;
        end else if (want_d) begin
          state_d  = busy_d;
          grant_d  = slot_d_d;
          pend_d_d = 1'b0;
          issue_d  = 1'b1;
        end
      end
      busy_i, busy_d: begin
        if (bus.rsp.mem_ready) begin
          state_d = idle;
        end
      end
      default: state_d = idle;
    endcase

`ifdef MEM_ARB_FAIRNESS_EN
    starve_cnt_d = starve_cnt_q;
    if (!want_i || (state_q == idle && state_d == busy_i)) begin
      starve_cnt_d = '0;
    end else if (state_q == idle && state_d == busy_d) begin
      starve_cnt_d = starve_cnt_q + cnt_w'(1);
    end
`endif
  end

  // Bus fields stay on the granted request for the whole busy phase; valid pulses once.
  always_comb begin
    bus.req          = '0;
    bus.req.mem_mode = m_mode;
    imem.rsp         = '0;
    dmem.rsp         = '0;

    if (state_q != idle) begin
      bus.req           = grant_q;
      bus.req.mem_valid = issue_q;
    end

    if (bus.rsp.mem_ready) begin
      if (state_q == busy_i) imem.rsp = bus.rsp;
      if (state_q == busy_d) dmem.rsp = bus.rsp;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-order scoreboard checks the bus and both
// responses every cycle, and each scenario pins latencies and response values with literals.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_port_if imem_if();
  mem_port_if dmem_if();
  mem_port_if bus_if();

  mem_arbiter dut (
    .clock(clock),
    .reset(reset),
    .imem (imem_if),
    .dmem (dmem_if),
    .bus  (bus_if)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // expected bus requests, in the order the arbitration rules say they must appear
  mem_in_type exp_q[$];
  mem_in_type cur;
  bit         have_out = 1'b0;
  int         last_rdy_cyc = -10;
  int         nvalid = 0;
  string      seq = "";

  function automatic mem_in_type mk(bit instr, logic [31:0] addr, logic [31:0] wdata,
                                    logic [3:0] wstrb, bit fence, bit spec);
    mem_in_type r;
    r           = '0;
    r.mem_valid = 1'b1;
    r.mem_instr = instr;
    r.mem_spec  = spec;
    r.mem_fence = fence;
    r.mem_mode  = 2'b11;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_in_type idle_req();
    mem_in_type r;
    r          = '0;
    r.mem_mode = 2'b11;
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  always @(negedge clock) begin : monitor
    mem_out_type exp_i, exp_d;
    mem_in_type  held;
    if (reset) begin
      have_out = 1'b0;
    end else begin
      if (bus_if.req.mem_valid) begin
        nvalid++;
        if (bus_if.req.mem_instr) seq = {seq, "I"};
        else                      seq = {seq, "D"};
        chk("bus_valid_while_busy", 128'(have_out), 128'(0));
        chk("bus_req_expected", 128'(exp_q.size() > 0), 128'(1));
        chk("issue_gap", 128'(cyc >= last_rdy_cyc + 2), 128'(1));
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          have_out = 1'b1;
          chk("bus_req_fields", 128'(bus_if.req), 128'(cur));
        end
      end else if (have_out) begin
        held           = cur;
        held.mem_valid = 1'b0;
        chk("bus_req_hold", 128'(bus_if.req), 128'(held));
      end else begin
        chk("bus_req_idle", 128'(bus_if.req), 128'(idle_req()));
      end

      exp_i = '0;
      exp_d = '0;
      if (bus_if.rsp.mem_ready && have_out) begin
        if (cur.mem_instr) exp_i = bus_if.rsp;
        else               exp_d = bus_if.rsp;
        have_out     = 1'b0;
        last_rdy_cyc = cyc;
      end
      chk("imem_rsp", 128'(imem_if.rsp), 128'(exp_i));
      chk("dmem_rsp", 128'(dmem_if.rsp), 128'(exp_d));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int vc);
    int n;
    n  = 0;
    vc = -1;
    while (n < 30) begin
      @(negedge clock);
      if (bus_if.req.mem_valid) begin
        vc = cyc;
        break;
      end
      n++;
    end
    chk("bus_valid_seen", 128'(vc >= 0), 128'(1));
    @(posedge clock);
    #1;
  endtask

  task automatic respond(input logic [31:0] rd, input logic err,
                         output mem_out_type io, output mem_out_type dm, output int rc);
    bus_if.rsp.mem_rdata = rd;
    bus_if.rsp.mem_error = err;
    bus_if.rsp.mem_ready = 1'b1;
    rc = cyc;
    @(negedge clock);
    io = imem_if.rsp;
    dm = dmem_if.rsp;
    @(posedge clock);
    #1;
    bus_if.rsp = '0;
  endtask

  initial begin
    int c0, vc, vc2, rc, n0, next_d;
    mem_out_type io, dm;

    imem_if.req = '0;
    dmem_if.req = '0;
    bus_if.rsp  = '0;
    reset       = 1'b1;
    tick();
    tick();
    chk("rst_bus_req", 128'(bus_if.req), 128'(idle_req()));
    chk("rst_imem_rsp", 128'(imem_if.rsp), 128'(0));
    chk("rst_dmem_rsp", 128'(dmem_if.rsp), 128'(0));
    reset = 1'b0;
    tick();

    // single fetch, ready three cycles after the bus request
    exp_q.push_back(mk(1, 32'h100, 32'h0, 4'h0, 0, 0));
    c0 = cyc;
    imem_if.req = mk(1, 32'h100, 32'h0, 4'h0, 0, 0);
    wait_valid(vc);
    chk("t1_issue_latency", 128'(vc), 128'(c0 + 1));
    tick();
    tick();
    respond(32'h0000_0013, 1'b0, io, dm, rc);
    chk("t1_ready_delay", 128'(rc), 128'(vc + 3));
    chk("t1_imem_ready", 128'(io.mem_ready), 128'(1));
    chk("t1_imem_rdata", 128'(io.mem_rdata), 128'(32'h13));
    chk("t1_dmem_quiet", 128'(dm), 128'(0));
    imem_if.req = '0;
    tick();

    // simultaneous requests: data first, fetch one idle cycle after the data ready
    seq = "";
    exp_q.push_back(mk(0, 32'h8000, 32'h11, 4'hF, 0, 0));
    exp_q.push_back(mk(1, 32'h200, 32'h0, 4'h0, 0, 0));
    c0 = cyc;
    dmem_if.req = mk(0, 32'h8000, 32'h11, 4'hF, 0, 0);
    imem_if.req = mk(1, 32'h200, 32'h0, 4'h0, 0, 0);
    wait_valid(vc);
    chk("t2_data_latency", 128'(vc), 128'(c0 + 1));
    dmem_if.req = '0;
    imem_if.req = '0;
    tick();
    respond(32'hAAAA_5555, 1'b0, io, dm, rc);
    chk("t2_dmem_ready", 128'(dm.mem_ready), 128'(1));
    chk("t2_imem_quiet", 128'(io), 128'(0));
    wait_valid(vc2);
    chk("t2_instr_issue", 128'(vc2), 128'(rc + 2));
    respond(32'h0000_1234, 1'b0, io, dm, rc);
    chk("t2_imem_rdata", 128'(io.mem_rdata), 128'(32'h1234));
    chk("t2_imem_ready", 128'(io.mem_ready), 128'(1));
    chk("t2_order", 128'(seq == "DI"), 128'(1));
    tick();

    // fetch valid held five cycles is one request
    n0 = nvalid;
    exp_q.push_back(mk(1, 32'h300, 32'h0, 4'h0, 0, 0));
    imem_if.req = mk(1, 32'h300, 32'h0, 4'h0, 0, 0);
    repeat (5) tick();
    imem_if.req = '0;
    respond(32'h0000_0033, 1'b0, io, dm, rc);
    repeat (4) tick();
    chk("t3_single_request", 128'(nvalid - n0), 128'(1));

    // reset while a data transaction is outstanding; its late ready is stray
    exp_q.push_back(mk(0, 32'h400, 32'h0, 4'h0, 0, 0));
    dmem_if.req = mk(0, 32'h400, 32'h0, 4'h0, 0, 0);
    wait_valid(vc);
    dmem_if.req = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    respond(32'h0000_DEAD, 1'b0, io, dm, rc);
    chk("t4_dmem_ready_after_reset", 128'(dm.mem_ready), 128'(0));
    chk("t4_imem_after_reset", 128'(io), 128'(0));
    chk("t4_bus_idle", 128'(bus_if.req), 128'(idle_req()));
    repeat (3) tick();

    // store completing with a bus error
    exp_q.push_back(mk(0, 32'h500, 32'hCAFE_F00D, 4'hF, 0, 0));
    dmem_if.req = mk(0, 32'h500, 32'hCAFE_F00D, 4'hF, 0, 0);
    wait_valid(vc);
    dmem_if.req = '0;
    tick();
    respond(32'h0, 1'b1, io, dm, rc);
    chk("t5_dmem_error", 128'(dm.mem_error), 128'(1));
    chk("t5_dmem_ready", 128'(dm.mem_ready), 128'(1));
    chk("t5_imem_quiet", 128'(io), 128'(0));
    tick();

    // fence and spec on a data request reach the bus unchanged
    exp_q.push_back(mk(0, 32'h600, 32'h0, 4'h0, 1, 1));
    dmem_if.req = mk(0, 32'h600, 32'h0, 4'h0, 1, 1);
    wait_valid(vc);
    dmem_if.req = '0;
    chk("t6_fence", 128'(bus_if.req.mem_fence), 128'(1));
    chk("t6_spec", 128'(bus_if.req.mem_spec), 128'(1));
    respond(32'h0000_0066, 1'b0, io, dm, rc);
    tick();

    // spec on the fetch port discards a queued fetch
    n0 = nvalid;
    exp_q.push_back(mk(0, 32'h680, 32'h0, 4'h0, 0, 0));
    dmem_if.req = mk(0, 32'h680, 32'h0, 4'h0, 0, 0);
    wait_valid(vc);
    dmem_if.req = '0;
    imem_if.req = mk(1, 32'h700, 32'h0, 4'h0, 0, 0);
    tick();
    imem_if.req = '0;
    imem_if.req.mem_spec = 1'b1;
    tick();
    imem_if.req = '0;
    respond(32'h0000_0068, 1'b0, io, dm, rc);
    repeat (4) tick();
    chk("t7_discarded_fetch", 128'(nvalid - n0), 128'(1));

    // new fetch arriving in the data ready cycle is issued after one idle cycle
    exp_q.push_back(mk(0, 32'h880, 32'h0, 4'h0, 0, 0));
    exp_q.push_back(mk(1, 32'h890, 32'h0, 4'h0, 0, 0));
    dmem_if.req = mk(0, 32'h880, 32'h0, 4'h0, 0, 0);
    wait_valid(vc);
    dmem_if.req = '0;
    imem_if.req = mk(1, 32'h890, 32'h0, 4'h0, 0, 0);
    respond(32'h0000_0088, 1'b0, io, dm, rc);
    imem_if.req = '0;
    wait_valid(vc2);
    chk("t8_fetch_issue", 128'(vc2), 128'(rc + 2));
    respond(32'h0000_0089, 1'b0, io, dm, rc);
    chk("t8_imem_rdata", 128'(io.mem_rdata), 128'(32'h89));
    tick();

    // stray ready while idle
    respond(32'h0000_0077, 1'b1, io, dm, rc);
    chk("t9_stray_imem", 128'(io), 128'(0));
    chk("t9_stray_dmem", 128'(dm), 128'(0));
    tick();

    // waiting fetch against back-to-back data requests
    seq = "";
`ifdef MEM_ARB_FAIRNESS_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 32'hA00 + 32'(k) * 16, 32'h0, 4'h0, 0, 0));
    exp_q.push_back(mk(1, 32'h900, 32'h0, 4'h0, 0, 0));
    exp_q.push_back(mk(0, 32'hA40, 32'h0, 4'h0, 0, 0));
`else
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(0, 32'hA00 + 32'(k) * 16, 32'h0, 4'h0, 0, 0));
    exp_q.push_back(mk(1, 32'h900, 32'h0, 4'h0, 0, 0));
`endif
    imem_if.req = mk(1, 32'h900, 32'h0, 4'h0, 0, 0);
    dmem_if.req = mk(0, 32'hA00, 32'h0, 4'h0, 0, 0);
    next_d = 1;
    for (int t = 0; t < 6; t++) begin
      wait_valid(vc);
      imem_if.req = '0;
      dmem_if.req = '0;
      respond(32'h1000 + 32'(t), 1'b0, io, dm, rc);
      if (next_d < 5) begin
        dmem_if.req = mk(0, 32'hA00 + 32'(next_d) * 16, 32'h0, 4'h0, 0, 0);
        next_d++;
        tick();
        dmem_if.req = '0;
      end
    end
`ifdef MEM_ARB_FAIRNESS_EN
    chk("t10_grant_order", 128'(seq == "DDDDID"), 128'(1));
`else
    chk("t10_grant_order", 128'(seq == "DDDDDI"), 128'(1));
`endif
    repeat (3) tick();

    chk("exp_queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
